// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : RV32I program counter and instruction-fetch sequencer with
//               stall, flush/redirect and misaligned-target detection.
// Revision    : 1.0 - initial release
// ============================================================================

module pc_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [XLEN-1:0] next_pc,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misalign_err
);

  localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_req_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic            r_instr_valid;
  logic            r_misalign;
  logic            r_kill;

  logic            w_flush_bad;
  logic            w_next_bad;

  assign w_flush_bad = (flush_pc[1:0] != 2'b00);
  assign w_next_bad  = (next_pc[1:0]  != 2'b00);

  // HALT is left only through rst; flush outranks every other input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_REQ;
      r_req_valid   <= 1'b1;
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_misalign    <= 1'b0;
      r_kill        <= 1'b0;
    end else if (r_state != ST_HALT) begin
      if (flush) begin
        r_instr_valid <= 1'b0;
        if (w_flush_bad) begin
          r_misalign  <= 1'b1;
          r_state     <= ST_HALT;
          r_req_valid <= 1'b0;
        end else begin
          r_pc <= flush_pc;
          // A response still in flight must be swallowed before refetching.
          if ((r_state == ST_WAIT) && !imem_rsp_valid) begin
            r_kill <= 1'b1;
          end else begin
            r_kill      <= 1'b0;
            r_state     <= ST_REQ;
            r_req_valid <= 1'b1;
          end
        end
      end else begin
        case (r_state)
          ST_REQ: begin
            if (imem_req_ready) begin
              r_state     <= ST_WAIT;
              r_req_valid <= 1'b0;
            end
          end
          ST_WAIT: begin
            if (imem_rsp_valid) begin
              if (r_kill) begin
                r_kill      <= 1'b0;
                r_state     <= ST_REQ;
                r_req_valid <= 1'b1;
              end else begin
                r_instr       <= imem_rsp_data;
                r_instr_valid <= 1'b1;
                r_state       <= ST_ISSUE;
              end
            end
          end
          ST_ISSUE: begin
            if (!stall) begin
              r_instr_valid <= 1'b0;
              if (w_next_bad) begin
                r_misalign <= 1'b1;
                r_state    <= ST_HALT;
              end else begin
                r_pc        <= next_pc;
                r_state     <= ST_REQ;
                r_req_valid <= 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = r_pc;
  assign instr_valid    = r_instr_valid;
  assign instr          = r_instr;
  assign pc             = r_pc;
  assign pc_plus4       = r_pc + c_pc_step;
  assign misalign_err   = r_misalign;

endmodule

`default_nettype wire
